// File: rtl/frame_101_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : frame_101_pkg                                                |
// | Description : Shared states, sync marker and helpers for frame_101_tx.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package frame_101_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GAP    = 3'd4
   } state_e;

   localparam logic [2:0] SYNC_PATTERN = 3'b101;
   localparam int         SYNC_LEN     = 3;
   // Two zeros are the least that return a 101 detector to idle.
   localparam int         GAP_LEN_MIN  = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Marker bit for a given position, first-sent bit first.
   function automatic logic sync_bit(input logic [1:0] idx);
      logic [1:0] pos;
      pos = 2'(SYNC_LEN - 1) - idx;
      return SYNC_PATTERN[pos];
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_101_shifter.sv
// +----------------------------------------------------------------------------+
// | Module      : frame_101_shifter                                            |
// | Description : Load/shift-left payload register with MSB taps and, when     |
// |               FRAME_101_TX_PARITY_EN is defined, a captured even parity.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_101_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              msb_o,
`ifdef FRAME_101_TX_PARITY_EN
   output logic              parity_o,
`endif
   output logic              next_msb_o
);

   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] w_shl;

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
      end else if (load_i) begin
         shreg_q <= data_i;
      end else if (shift_i) begin
         shreg_q <= w_shl;
      end
   end

   assign msb_o = shreg_q[DATA_W-1];

   // next_msb_o is the bit that becomes the MSB after the pending shift.
   generate
      if (DATA_W > 1) begin : g_wide
         assign w_shl      = {shreg_q[DATA_W-2:0], 1'b0};
         assign next_msb_o = shreg_q[DATA_W-2];
      end else begin : g_narrow
         assign w_shl      = '0;
         assign next_msb_o = 1'b0;
      end
   endgenerate

`ifdef FRAME_101_TX_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else if (load_i) begin
         parity_q <= ^data_i;
      end
   end

   assign parity_o = parity_q;
`endif

endmodule

`default_nettype wire

// File: rtl/frame_101_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : frame_101_tx                                                 |
// | Description : Framed serial transmitter (101 marker, payload MSB first,    |
// |               optional even parity via FRAME_101_TX_PARITY_EN, zero gap).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_101_tx
   import frame_101_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              out_bit,
   output logic              out_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int                 C_CNT_W     = $clog2(max3(DATA_W, GAP_LEN, SYNC_LEN) + 1);
   localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0] C_SYNC_LAST = C_CNT_W'(SYNC_LEN - 1);
   localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_W - 1);
   localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GAP_LEN - 1);

   state_e             state_q, state_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic               tx_ready_q, tx_ready_d;
   logic               out_bit_q, out_bit_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;

   logic               w_accept;
   logic               w_msb;
   logic               w_next_msb;
`ifdef FRAME_101_TX_PARITY_EN
   logic               w_parity;
`endif

   assign w_accept = tx_valid && tx_ready_q;

   frame_101_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_accept),
      .shift_i    (state_q == DATA),
      .data_i     (tx_data),
      .msb_o      (w_msb),
`ifdef FRAME_101_TX_PARITY_EN
      .parity_o   (w_parity),
`endif
      .next_msb_o (w_next_msb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         tx_ready_q   <= 1'b1;
         out_bit_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tx_ready_q   <= tx_ready_d;
         out_bit_q    <= out_bit_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + C_ONE;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (w_accept) state_d = SYNC;
         end
         SYNC: begin
            if (cnt_q == C_SYNC_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (cnt_q == C_DATA_LAST) begin
`ifdef FRAME_101_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = GAP;
`endif
               cnt_d   = '0;
            end
         end
`ifdef FRAME_101_TX_PARITY_EN
         PARITY: begin
            state_d = GAP;
            cnt_d   = '0;
         end
`endif
         GAP: begin
            if (cnt_q == C_GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state, so they line up with it.
   always_comb begin
      out_bit_d = 1'b0;
      unique case (state_d)
         SYNC:    out_bit_d = sync_bit(2'(cnt_d));
         DATA:    out_bit_d = (state_q == DATA) ? w_next_msb : w_msb;
`ifdef FRAME_101_TX_PARITY_EN
         PARITY:  out_bit_d = w_parity;
`endif
         default: out_bit_d = 1'b0;
      endcase
      out_valid_d  = (state_d == SYNC) || (state_d == DATA) || (state_d == PARITY);
      busy_d       = (state_d != IDLE);
      tx_ready_d   = (state_d == IDLE);
      frame_done_d = (state_d == GAP) && (cnt_d == C_GAP_LAST);
   end

   assign tx_ready   = tx_ready_q;
   assign out_bit    = out_bit_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: doc/frame_101_tx.md
# frame_101_tx

Serial frame transmitter producing the single-bit stream consumed by the team's "101" Mealy sequence detectors. Each accepted word goes out as a framed burst:
- sync marker 1,0,1
- payload, MSB first
- optional even-parity bit
- a zero gap that returns any downstream 101 detector to its idle state

It sits between a word-level producer (valid/ready) and the serial line feeding the detector.

## Interface
- DATA_W, default 8: payload width in bits; legal range is 1 or more.
- GAP_LEN, default 2: number of trailing zero bits per frame; minimum is 2, so the detector always reaches its idle state.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- tx_data  input  DATA_W  payload word, sampled on accept
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept a word (IDLE only)
- out_bit  output  1  serial line bit
- out_valid  output  1  out_bit belongs to sync, payload or parity
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse on the last gap bit

## Operation
- One clock; reset is synchronous and active-high.
- States:
  - IDLE
  - SYNC (3 bits)
  - DATA (DATA_W bits)
  - PARITY (1 bit, present only with the macro)
  - GAP (GAP_LEN bits)
- Transitions:
  - IDLE→SYNC on tx_valid && tx_ready.
  - SYNC→DATA after bit 3.
  - DATA→PARITY, or DATA→GAP when parity is disabled, after DATA_W bits.
  - PARITY→GAP after 1 bit.
  - GAP→IDLE after GAP_LEN bits.
- On accept, tx_data is captured into a shift register and parity is computed from the captured word. Later changes on tx_data have no effect.
- out_bit per state:
  - SYNC: 1,0,1 in order.
  - DATA: shift-register MSB, then shift left.
  - PARITY: XOR of all captured bits (even parity).
  - IDLE and GAP: 0.
- out_valid is 1 in SYNC, DATA and PARITY; 0 in IDLE and GAP.
- tx_valid while not ready is ignored and not queued. The producer must hold it.
- A payload containing 101 may trigger the detector mid-frame. Framing is the receiver's concern; this block does not stuff bits.
- Single bit counter, width $clog2(max(DATA_W,GAP_LEN,3)+1). It resets to 0 on each state entry.

## Timing
- Reset values: tx_ready=1, out_bit=0, out_valid=0, busy=0, frame_done=0. State is IDLE, counter 0, shift register 0.
- Reset asserted mid-frame: at the next edge the frame is dropped and all outputs return to their reset values. No partial gap is emitted.
- Latency: the accept edge is T. The first sync bit is on out_bit during cycle T+1, and all outputs are registered.
- Frame length F = 3 + DATA_W + P + GAP_LEN cycles, where P = 1 with parity and 0 without.
- frame_done is high in the final GAP cycle. tx_ready rises the cycle after.
- Minimum accept-to-accept spacing is F+1 cycles, because one IDLE cycle is mandatory.
- tx_ready is low for exactly F cycles after each accept.

## Configuration
- Macro: FRAME_101_TX_PARITY_EN.
- Defined: the PARITY state is present, P=1, and the even-parity bit is sent with out_valid=1.
- Undefined: DATA goes directly to GAP, P=0, and the parity logic is not compiled.
- The port list is identical in both builds.

## Structure
- Shared package frame_101_pkg holds:
  - the state enum (IDLE, SYNC, DATA, PARITY, GAP)
  - SYNC_PATTERN = 3'b101
  - SYNC_LEN = 3
  - the GAP_LEN minimum constant
- One sub-module: frame_101_shifter. It is a DATA_W-bit load/shift-left register with MSB output and a parity output.
- The FSM, counter and output registers stay in the top.

## Test plan
- Reset, then idle: hold reset 2 cycles and release. Required: tx_ready=1, busy=0, out_valid=0, out_bit=0 for 10 cycles.
- Send 8'hA5 with parity enabled and GAP_LEN=2. Required:
  - out_bit = 1,0,1,1,0,1,0,0,1,0,1,0,0,0
  - out_valid high for the first 12 bits
  - frame_done high on bit 14
  - tx_ready high at T+15
- Send 8'h07 with parity enabled. Required: parity bit 1 after payload 0,0,0,0,0,1,1,1.
- Send 8'hFF with the macro undefined. Required: 1,0,1, then eight 1s, then 0,0. Frame length is 13, with no parity cycle.
- Back-to-back: tx_valid held high with 8'h3C then 8'hC3. Required: the second accept happens exactly 15 cycles after the first. tx_data changes during the first frame do not alter its bits.
- Reset mid-frame: assert reset during payload bit 4. Required: the next cycle out_valid=0 and tx_ready=1. A following frame of 8'h81 is transmitted correctly.
